// File: rtl/btn_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// The four channel states are encoded as a 2-bit enum.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    // 10 ms at 100 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, press/release qualification FSM,
// stability counter and registered level/pulse outputs.
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic i_rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int NB_CNT = $clog2(DEBOUNCE_CYCLES);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

    logic              meta;
    logic              sync;
    state_t            state;
    state_t            state_next;
    logic [NB_CNT-1:0] cnt;
    logic [NB_CNT-1:0] cnt_next;
    logic              pulse_next;
    logic              level_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            meta  <= raw;
            sync  <= meta;
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
            pulse <= pulse_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pulse_next = 1'b0;

        unique case (state)
            IDLE: begin
                if (sync) begin
                    state_next = WAIT_PRESS;
                    cnt_next   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!sync) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt + NB_CNT'(1);
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_next = WAIT_RELEASE;
                    cnt_next   = '0;
                end
            end
            WAIT_RELEASE: begin
                // Bounce during release returns to PRESSED without a new pulse
                if (sync) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + NB_CNT'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        level_next = (state_next == PRESSED) || (state_next == WAIT_RELEASE);
    end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: NB_BTN independent debounce channels
// producing a clean level and a one-cycle press pulse per button.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int NB_BTN          = 3,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic [NB_BTN-1:0] i_btn_raw,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic [NB_BTN-1:0] o_btn_pulse
);

    for (genvar i = 0; i < NB_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .i_rst(i_rst),
            .raw  (i_btn_raw[i]),
            .level(o_btn_level[i]),
            .pulse(o_btn_pulse[i])
        );
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Multi-channel push-button conditioner that sits directly upstream of the ALU top's button inputs. Each raw board button is synchronised into the clock domain, filtered against contact bounce, and converted into a clean debounced level and a single-cycle press pulse. The ALU top's operand/opcode load strobes connect to `o_btn_pulse`, so each physical press loads exactly once.

## Interface
- `NB_BTN`, 3: number of independent button channels.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a press or a release (10 ms at 100 MHz). Legal range is ≥ 2.
- `NB_CNT`, `$clog2(DEBOUNCE_CYCLES)`: stability counter width. Derived; never overridden.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `i_rst`  in  1  asynchronous, active-low reset.
- `i_btn_raw`  in  NB_BTN  raw, asynchronous, bouncing button inputs. Active-high.
- `o_btn_level`  out  NB_BTN  debounced button level, registered.
- `o_btn_pulse`  out  NB_BTN  one-cycle pulse per accepted press, registered.

## Operation
- Channels are fully independent. There is no arbitration; simultaneous presses pulse simultaneously.
- Each channel has a 2-FF synchroniser on `i_btn_raw[i]`, producing `sync[i]`. All logic below uses `sync` only.
- Per-channel FSM (IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE) with an NB_CNT-bit counter:
  - IDLE: level 0. `sync`=1 → WAIT_PRESS, cnt←0.
  - WAIT_PRESS: level 0.
    - `sync`=0 → IDLE.
    - `sync`=1 and cnt==DEBOUNCE_CYCLES-1 → PRESSED. This transition sets pulse for one cycle.
    - Otherwise cnt++.
  - PRESSED: level 1. `sync`=0 → WAIT_RELEASE, cnt←0.
  - WAIT_RELEASE: level 1.
    - `sync`=1 → PRESSED. No new pulse is generated.
    - `sync`=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE.
    - Otherwise cnt++.
- `o_btn_level` = 1 in PRESSED and WAIT_RELEASE, 0 otherwise.
- `o_btn_pulse` = 1 only in the first cycle after entering PRESSED from WAIT_PRESS.
- Counter never wraps. It is compared against DEBOUNCE_CYCLES-1 and reset on every state entry.
- A glitch shorter than DEBOUNCE_CYCLES sync cycles produces no level change and no pulse.

## Timing
- Reset (`i_rst`=0) forces the following, asynchronously:
  - sync FFs 0, state IDLE, cnt 0.
  - `o_btn_level`=0, `o_btn_pulse`=0.
- Press latency: if raw goes high and stays high, the pulse appears after the (DEBOUNCE_CYCLES+3)-th rising edge, counting the first edge that samples raw=1. This is 2 synchroniser cycles + 1 IDLE→WAIT_PRESS cycle + DEBOUNCE_CYCLES qualification cycles.
- `o_btn_level` rises in the same cycle as `o_btn_pulse`.
- Release latency: `o_btn_level` falls DEBOUNCE_CYCLES+3 edges after the first edge that samples raw=0.
- Pulse width is exactly 1 cycle, independent of hold time.
- A button held through reset deassertion is re-qualified from IDLE. One pulse follows after the full press latency.
- Reset asserted mid-press or mid-release aborts the sequence. No pulse is emitted during reset.
- Reset deassertion is synchronised externally. The block only requires async assert.

## Structure
- Shared package `btn_debounce_pkg`:
  - state enum/localparams: IDLE=2'd0, WAIT_PRESS=2'd1, PRESSED=2'd2, WAIT_RELEASE=2'd3.
  - default DEBOUNCE_CYCLES constant.
- One sub-module, `btn_debounce_ch`: a single channel containing the synchroniser, FSM, counter, and output registers.
- Top `btn_debounce` instantiates NB_BTN copies via a generate loop.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 unless stated.
- Clean press: raw[0] 0→1 and held 20 cycles → `o_btn_pulse`=3'b001 for exactly one cycle after edge 7. `o_btn_level[0]` stays 1 until release. Other channels stay 0.
- Bounce: raw[1] toggles 1,0,1,1,0,1 on successive cycles, then holds 1 → no pulse during bouncing. One pulse 7 edges after the final stable 1.
- Release bounce: while pressed, raw[0] drops to 0 for 2 cycles, then returns to 1 → level stays 1 and no second pulse. After a stable release, level falls 7 edges after the first sampled 0.
- Simultaneous: raw = 3'b111 on the same edge → `o_btn_pulse`=3'b111 in a single cycle.
- Reset mid-operation: assert `i_rst`=0 with raw[2] held during WAIT_PRESS → all outputs 0 immediately. Release reset with raw still held → exactly one pulse 7 edges later.
- Long hold: DEBOUNCE_CYCLES=1000, hold 5000 cycles → exactly one pulse. Counter does not wrap or overflow.
